// File: rtl/instr_fetch.sv
// Instruction fetch: pulls one word from instruction memory and holds it for decode.
// Latency: one FETCH cycle plus any memory wait, then HOLD; best case one instruction per 2 cycles.
// Backpressure: imemReq stays up until imemAck; the held instruction stays put until instrReady.
module instr_fetch (
  input  logic        clk,
  input  logic        rstN,
  output logic        imemReq,
  output logic [31:0] imemAddr,
  input  logic        imemAck,
  input  logic [31:0] imemData,
  output logic        instrValid,
  output logic [31:0] instr,
  output logic [5:0]  opcode,
  output logic [5:0]  funct,
  output logic [31:0] pc,
  input  logic        instrReady,
  input  logic        pcSrc,
  input  logic [15:0] branchOffset,
  input  logic        jump,
  input  logic [25:0] jumpTarget
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t      state_q;
  state_t      state_d;
  logic [31:0] pc_q;
  logic [31:0] instr_q;
  logic [31:0] pc_plus4;
  logic [31:0] branch_tgt;
  logic [31:0] next_pc;
  logic        capture;
  logic        accept;

  assign pc_plus4   = pc_q + 32'd4;
  assign branch_tgt = pc_plus4 + {{14{branchOffset[15]}}, branchOffset, 2'b00};

  // Jump outranks a taken branch when decode asserts both.
  always_comb begin
    next_pc = pc_plus4;
    if (jump) begin
      next_pc = {pc_plus4[31:28], jumpTarget, 2'b00};
    end else if (pcSrc) begin
      next_pc = branch_tgt;
    end
  end

  assign capture = (state_q == FETCH) && imemAck;
  assign accept  = (state_q == HOLD) && instrReady;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = FETCH;
      FETCH:   if (imemAck) state_d = HOLD;
      HOLD:    if (instrReady) state_d = FETCH;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state_q <= IDLE;
      pc_q    <= 32'h0000_0000;
      instr_q <= 32'h0000_0000;
    end else begin
      state_q <= state_d;
      if (capture) begin
        instr_q <= imemData;
      end
      if (accept) begin
        pc_q <= next_pc;
      end
    end
  end

  // Outputs decode straight from registered state so reset clears them without a clock.
  assign imemReq    = (state_q == FETCH);
  assign imemAddr   = pc_q;
  assign instrValid = (state_q == HOLD);
  assign instr      = instr_q;
  assign pc         = pc_q;
  assign opcode     = instr_q[31:26];
  assign funct      = instr_q[5:0];

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: inputs change and outputs are checked on the falling edge.
module tb_instr_fetch;

  logic        clk;
  logic        rstN;
  logic        imemReq;
  logic [31:0] imemAddr;
  logic        imemAck;
  logic [31:0] imemData;
  logic        instrValid;
  logic [31:0] instr;
  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic [31:0] pc;
  logic        instrReady;
  logic        pcSrc;
  logic [15:0] branchOffset;
  logic        jump;
  logic [25:0] jumpTarget;

  int total;
  int bad;

  instr_fetch dut (
    .clk          (clk),
    .rstN         (rstN),
    .imemReq      (imemReq),
    .imemAddr     (imemAddr),
    .imemAck      (imemAck),
    .imemData     (imemData),
    .instrValid   (instrValid),
    .instr        (instr),
    .opcode       (opcode),
    .funct        (funct),
    .pc           (pc),
    .instrReady   (instrReady),
    .pcSrc        (pcSrc),
    .branchOffset (branchOffset),
    .jump         (jump),
    .jumpTarget   (jumpTarget)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Present one memory response in FETCH; returns on the next falling edge in HOLD.
  task automatic do_fetch(input logic [31:0] d);
    imemAck  = 1'b1;
    imemData = d;
    @(negedge clk);
    imemAck  = 1'b0;
  endtask

  // Accept the held instruction with the given redirect inputs; returns in FETCH.
  task automatic do_accept(input logic j, input logic ps, input logic [15:0] off,
                           input logic [25:0] tgt);
    instrReady   = 1'b1;
    jump         = j;
    pcSrc        = ps;
    branchOffset = off;
    jumpTarget   = tgt;
    @(negedge clk);
    instrReady   = 1'b0;
    jump         = 1'b0;
    pcSrc        = 1'b0;
    branchOffset = 16'h0;
    jumpTarget   = 26'h0;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rstN = 1'b0; imemAck = 1'b0; imemData = 32'h0; instrReady = 1'b0;
    pcSrc = 1'b0; branchOffset = 16'h0; jump = 1'b0; jumpTarget = 26'h0;

    repeat (2) @(negedge clk);
    chk("rst_req",   {31'd0, imemReq},    32'd0);
    chk("rst_valid", {31'd0, instrValid}, 32'd0);
    chk("rst_pc",    pc,                  32'h0);
    chk("rst_instr", instr,               32'h0);

    // First fetch after release goes to address 0.
    rstN = 1'b1;
    @(negedge clk);
    chk("first_req",   {31'd0, imemReq},    32'd1);
    chk("first_addr",  imemAddr,            32'h0);
    chk("first_valid", {31'd0, instrValid}, 32'd0);
    do_fetch(32'h2008_0005);
    chk("first_hold_valid", {31'd0, instrValid}, 32'd1);
    chk("first_hold_req",   {31'd0, imemReq},    32'd0);
    chk("first_opcode",     {26'd0, opcode},     32'h08);
    chk("first_funct",      {26'd0, funct},      32'h05);
    chk("first_pc",         pc,                  32'h0);

    // Sequential flow 0 -> 4 -> 8 with a three-cycle memory wait at 8.
    do_accept(1'b0, 1'b0, 16'h0, 26'h0);
    chk("seq_addr4", imemAddr, 32'h4);
    do_fetch(32'h0000_0020);
    chk("seq_pc4",    pc,              32'h4);
    chk("seq_funct4", {26'd0, funct},  32'h20);
    do_accept(1'b0, 1'b0, 16'h0, 26'h0);
    // Redirect inputs outside HOLD must not move pc.
    instrReady = 1'b1; jump = 1'b1; jumpTarget = 26'h3FF;
    for (int i = 0; i < 3; i++) begin
      chk("wait_req",   {31'd0, imemReq},    32'd1);
      chk("wait_addr",  imemAddr,            32'h8);
      chk("wait_valid", {31'd0, instrValid}, 32'd0);
      @(negedge clk);
    end
    instrReady = 1'b0; jump = 1'b0; jumpTarget = 26'h0;
    chk("wait_addr_after", imemAddr, 32'h8);
    do_fetch(32'h0000_0000);
    chk("seq_pc8", pc, 32'h8);

    // Branches from 0x10: offset -2 words and +3 words.
    do_accept(1'b1, 1'b0, 16'h0, 26'h000_0004);
    chk("jmp_addr10", imemAddr, 32'h10);
    do_fetch(32'h1000_0000);
    do_accept(1'b0, 1'b1, 16'hFFFE, 26'h0);
    chk("br_back_addr", imemAddr, 32'h0C);
    do_fetch(32'h0);
    do_accept(1'b1, 1'b0, 16'h0, 26'h000_0004);
    do_fetch(32'h1000_0000);
    chk("br_pc10", pc, 32'h10);
    do_accept(1'b0, 1'b1, 16'h0003, 26'h0);
    chk("br_fwd_addr", imemAddr, 32'h20);
    do_fetch(32'h0);

    // Jump wins over a simultaneous taken branch.
    do_accept(1'b1, 1'b0, 16'h0, 26'h000_0010);
    chk("jmp_addr40", imemAddr, 32'h40);
    do_fetch(32'h0800_0100);
    do_accept(1'b1, 1'b1, 16'h0003, 26'h000_0100);
    chk("jmp_prio_addr", imemAddr, 32'h400);
    do_fetch(32'h0);

    // Branch from 0x400 back to 0xFFFFFFFC, stall there, then wrap to 0.
    do_accept(1'b0, 1'b1, 16'hFEFE, 26'h0);
    chk("br_neg_addr", imemAddr, 32'hFFFF_FFFC);
    do_fetch(32'hDEAD_BEEF);
    imemAck = 1'b1; imemData = 32'h1234_5678;
    for (int i = 0; i < 5; i++) begin
      chk("stall_valid", {31'd0, instrValid}, 32'd1);
      chk("stall_pc",    pc,                  32'hFFFF_FFFC);
      chk("stall_instr", instr,               32'hDEAD_BEEF);
      @(negedge clk);
    end
    imemAck = 1'b0;
    do_accept(1'b0, 1'b0, 16'h0, 26'h0);
    chk("wrap_addr", imemAddr, 32'h0);
    chk("wrap_req",  {31'd0, imemReq}, 32'd1);

    // Reset in the middle of a fetch at pc 4, with a stray ack around it.
    do_fetch(32'h0);
    do_accept(1'b0, 1'b0, 16'h0, 26'h0);
    chk("pre_rst_addr", imemAddr, 32'h4);
    rstN = 1'b0;
    #1;
    chk("midrst_req",  {31'd0, imemReq},    32'd0);
    chk("midrst_pc",   pc,                  32'h0);
    chk("midrst_addr", imemAddr,            32'h0);
    imemAck = 1'b1; imemData = 32'hCAFE_F00D;
    @(negedge clk);
    chk("rst_ack_valid", {31'd0, instrValid}, 32'd0);
    rstN = 1'b1;
    @(negedge clk);
    imemAck = 1'b0;
    chk("post_rst_valid", {31'd0, instrValid}, 32'd0);
    chk("post_rst_instr", instr,               32'h0);
    chk("post_rst_req",   {31'd0, imemReq},    32'd1);
    chk("post_rst_addr",  imemAddr,            32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
